// File: rtl/phgate_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : phgate_pkg                                                        |
// | Brief   : Shared widths, sequencer state encoding and command record.       |
// | Rev     : 1.0                                                               |
// +-----------------------------------------------------------------------------+
package phgate_pkg;

  localparam int PHW_DEF  = 27;
  localparam int LENW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Default-width command record; the top re-declares it at its instance widths.
  typedef struct packed {
    logic [PHW_DEF-1:0]  freq;
    logic [PHW_DEF-1:0]  tstart;
    logic [LENW_DEF-1:0] len;
    logic                phrst;
  } cmd_t;

endpackage
`default_nettype wire

// File: rtl/phgate_slot.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : phgate_slot                                                       |
// | Brief   : One command holding register with valid flag; load beats clear.   |
// | Rev     : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module phgate_slot
  import phgate_pkg::*;
#(
  parameter type T = cmd_t
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_load,
  input  logic i_clear,
  input  T     i_cmd,
  output logic o_valid,
  output T     o_cmd
);

  logic r_valid;
  T     r_cmd;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_cmd   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_cmd   <= i_cmd;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_cmd   = r_cmd;

endmodule
`default_nettype wire

// File: rtl/phgate_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : phgate_seq                                                        |
// | Brief   : Timed pulse-gate sequencer feeding a phase/time multiplier.       |
// |           Define PHGATE_SEQ_PREFETCH_EN to add a pending command slot.      |
// | Rev     : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module phgate_seq
  import phgate_pkg::*;
#(
  parameter int PHW  = PHW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [PHW-1:0]  cmd_freq,
  input  logic [PHW-1:0]  cmd_tstart,
  input  logic [LENW-1:0] cmd_len,
  input  logic            cmd_phrst,
  output logic [PHW-1:0]  time_now,
  output logic [PHW-1:0]  freq,
  output logic [PHW-1:0]  tcnt,
  output logic            gate,
  output logic            late_err,
  output logic            busy
);

  typedef struct packed {
    logic [PHW-1:0]  freq;
    logic [PHW-1:0]  tstart;
    logic [LENW-1:0] len;
    logic            phrst;
  } slot_cmd_t;

  // Late: start is under two cycles away or already in the past (modular).
  function automatic logic f_is_late(input logic [PHW-1:0] tstart,
                                     input logic [PHW-1:0] now);
    logic [PHW-1:0] d;
    d = tstart - now;
    return (d < PHW'(2)) || d[PHW-1];
  endfunction

  state_t          r_state;
  logic [PHW-1:0]  r_time;
  logic [PHW-1:0]  r_freq;
  logic [PHW-1:0]  r_tcnt;
  logic [LENW-1:0] r_remain;
  logic            r_gate;
  logic            r_late;
  logic            r_late_err;
  logic            r_ready;

  logic [PHW-1:0]  w_time_nx;
  slot_cmd_t       w_in;
  slot_cmd_t       w_a_cmd;
  slot_cmd_t       w_p_cmd;
  slot_cmd_t       w_cand;
  slot_cmd_t       w_go_cmd;
  logic            w_a_valid;
  logic            w_p_valid;
  logic            w_in_ok;
  logic            w_run_end;
  logic            w_promote;
  logic            w_cand_late;
  logic            w_a_load;
  logic            w_a_clear;
  logic            w_go;
  logic            w_ready_nx;

  assign w_time_nx   = r_time + PHW'(1);
  assign w_in        = {cmd_freq, cmd_tstart, cmd_len, cmd_phrst};
  assign w_in_ok     = cmd_valid && r_ready && (cmd_len != '0);
  assign w_run_end   = (r_state == ST_RUN) && (r_remain == '0);
  // The pending slot takes precedence; with it empty a same-cycle handshake is promoted directly.
  assign w_cand      = w_p_valid ? w_p_cmd : w_in;
  assign w_cand_late = f_is_late(w_cand.tstart, r_time);
  assign w_promote   = w_run_end && (w_p_valid || w_in_ok);
  assign w_a_load    = ((r_state == ST_IDLE) && w_in_ok) || w_promote;
  assign w_a_clear   = w_run_end && !w_promote;
  assign w_go        = ((r_state == ST_WAIT) && w_a_valid &&
                        (r_late || (w_a_cmd.tstart == w_time_nx))) ||
                       (w_promote && (w_cand.tstart == w_time_nx));
  assign w_go_cmd    = (r_state == ST_WAIT) ? w_a_cmd : w_cand;

  phgate_slot #(.T(slot_cmd_t)) u_active (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_a_load),
    .i_clear (w_a_clear),
    .i_cmd   (w_cand),
    .o_valid (w_a_valid),
    .o_cmd   (w_a_cmd)
  );

`ifdef PHGATE_SEQ_PREFETCH_EN
  logic w_p_load;
  logic w_p_clear;

  assign w_p_load  = w_in_ok && ((r_state == ST_WAIT) || ((r_state == ST_RUN) && !w_run_end));
  assign w_p_clear = w_promote && w_p_valid;

  phgate_slot #(.T(slot_cmd_t)) u_pend (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_p_load),
    .i_clear (w_p_clear),
    .i_cmd   (w_in),
    .o_valid (w_p_valid),
    .o_cmd   (w_p_cmd)
  );

  assign w_ready_nx = !(w_p_load || (w_p_valid && !w_p_clear));
`else
  assign w_p_valid  = 1'b0;
  assign w_p_cmd    = '0;
  assign w_ready_nx = ((r_state == ST_IDLE) && !w_a_load) || w_run_end;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_time     <= '0;
      r_freq     <= '0;
      r_tcnt     <= '0;
      r_remain   <= '0;
      r_gate     <= 1'b0;
      r_late     <= 1'b0;
      r_late_err <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_time     <= w_time_nx;
      r_late_err <= 1'b0;
      r_ready    <= w_ready_nx;
      r_tcnt     <= w_time_nx;
      if (w_go) begin
        r_state  <= ST_RUN;
        r_gate   <= 1'b1;
        r_late   <= 1'b0;
        r_remain <= w_go_cmd.len - LENW'(1);
        r_freq   <= w_go_cmd.freq;
        if (w_go_cmd.phrst) r_tcnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_a_load) begin
              r_state    <= ST_WAIT;
              r_late     <= w_cand_late;
              r_late_err <= w_cand_late;
            end
          end
          ST_WAIT: begin
          end
          ST_RUN: begin
            if (r_remain != '0) begin
              r_remain <= r_remain - LENW'(1);
              if (w_a_cmd.phrst) r_tcnt <= r_tcnt + PHW'(1);
            end else if (w_promote) begin
              r_state    <= ST_WAIT;
              r_gate     <= 1'b0;
              r_late     <= w_cand_late;
              r_late_err <= w_cand_late;
            end else begin
              r_state <= ST_IDLE;
              r_gate  <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready = r_ready;
  assign time_now  = r_time;
  assign freq      = r_freq;
  assign tcnt      = r_tcnt;
  assign gate      = r_gate;
  assign late_err  = r_late_err;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
